// File: rtl/dit_ifft8.sv
// dit_ifft8: iterative 8-point radix-2 DIT inverse FFT with one time-shared
// butterfly, 1/2 scaling per stage, valid/ready frame handshake on both sides.
module dit_ifft8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x_real,
    input  logic [63:0] x_img,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y_real,
    output logic [63:0] y_img
);

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 8;   // sample width
    localparam int unsigned CW = 9;   // twiddle width (must hold +128)
    localparam int unsigned PW = 18;  // product/accumulator width
    localparam int unsigned TW = 10;  // rotated operand width
    localparam int unsigned SW = 11;  // butterfly sum width

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e               state_q;
    logic [1:0]           s_q;
    logic [1:0]           b_q;
    logic signed [DW-1:0] mem_re_q [N];
    logic signed [DW-1:0] mem_im_q [N];
    logic signed [DW-1:0] mem_re_d [N];
    logic signed [DW-1:0] mem_im_d [N];

    logic [2:0]           p_c;
    logic [2:0]           q_c;
    logic [1:0]           k_c;
    logic signed [CW-1:0] c_c;
    logic signed [CW-1:0] sn_c;
    logic signed [PW-1:0] acc_re_c;
    logic signed [PW-1:0] acc_im_c;
    logic signed [TW-1:0] t_re_c;
    logic signed [TW-1:0] t_im_c;
    logic signed [SW-1:0] sum_re_c;
    logic signed [SW-1:0] sum_im_c;
    logic signed [SW-1:0] dif_re_c;
    logic signed [SW-1:0] dif_im_c;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    function automatic logic signed [DW-1:0] sat8(input logic signed [SW-1:0] v);
        if (v > 11'sd127)
            return 8'sd127;
        else if (v < -11'sd128)
            return -8'sd128;
        else
            return DW'(v);
    endfunction

    // Butterfly pair and twiddle index for the current (stage, butterfly)
    always_comb begin
        p_c = '0;
        q_c = '0;
        k_c = '0;
        case (s_q)
            2'd0: begin
                p_c = {b_q, 1'b0};
                q_c = {b_q, 1'b1};
            end
            2'd1: begin
                p_c = {b_q[1], 1'b0, b_q[0]};
                q_c = {b_q[1], 1'b1, b_q[0]};
                k_c = {b_q[0], 1'b0};
            end
            default: begin
                p_c = {1'b0, b_q};
                q_c = {1'b1, b_q};
                k_c = b_q;
            end
        endcase
    end

    // Inverse twiddle W^-k as (cos, sin) in Q1.7
    always_comb begin
        c_c  = 9'sd128;
        sn_c = 9'sd0;
        case (k_c)
            2'd0: begin c_c = 9'sd128;  sn_c = 9'sd0;   end
            2'd1: begin c_c = 9'sd91;   sn_c = 9'sd91;  end
            2'd2: begin c_c = 9'sd0;    sn_c = 9'sd128; end
            default: begin c_c = -9'sd91; sn_c = 9'sd91; end
        endcase
    end

    // Scaled butterfly; produces the memory image after this cycle's update
    always_comb begin
        acc_re_c = PW'(mem_re_q[q_c]) * PW'(c_c)  - PW'(mem_im_q[q_c]) * PW'(sn_c);
        acc_im_c = PW'(mem_re_q[q_c]) * PW'(sn_c) + PW'(mem_im_q[q_c]) * PW'(c_c);
        t_re_c   = TW'(acc_re_c >>> 7);
        t_im_c   = TW'(acc_im_c >>> 7);
        sum_re_c = SW'(mem_re_q[p_c]) + SW'(t_re_c);
        sum_im_c = SW'(mem_im_q[p_c]) + SW'(t_im_c);
        dif_re_c = SW'(mem_re_q[p_c]) - SW'(t_re_c);
        dif_im_c = SW'(mem_im_q[p_c]) - SW'(t_im_c);
        mem_re_d = mem_re_q;
        mem_im_d = mem_im_q;
        mem_re_d[p_c] = sat8(sum_re_c >>> 1);
        mem_im_d[p_c] = sat8(sum_im_c >>> 1);
        mem_re_d[q_c] = sat8(dif_re_c >>> 1);
        mem_im_d[q_c] = sat8(dif_im_c >>> 1);
    end

    // Frame FSM: bit-reversed load, 12 butterfly cycles, held result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            b_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y_real    <= '0;
            y_img     <= '0;
            for (int i = 0; i < N; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < N; k++) begin
                            mem_re_q[bitrev3(3'(k))] <= x_real[DW*k +: DW];
                            mem_im_q[bitrev3(3'(k))] <= x_img[DW*k +: DW];
                        end
                        s_q      <= '0;
                        b_q      <= '0;
                        in_ready <= 1'b0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    mem_re_q <= mem_re_d;
                    mem_im_q <= mem_im_d;
                    b_q      <= b_q + 2'd1;
                    if (b_q == 2'd3)
                        s_q <= s_q + 2'd1;
                    if (s_q == 2'd2 && b_q == 2'd3) begin
                        s_q       <= '0;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                        for (int n = 0; n < N; n++) begin
                            y_real[DW*n +: DW] <= mem_re_d[n];
                            y_img[DW*n +: DW]  <= mem_im_d[n];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dit_ifft8.sv
// Scoreboard bench for dit_ifft8: directed tones, handshake, reset abort and
// random frames against a loop-based IFFT reference.
module tb_dit_ifft8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] x_real = '0;
    logic [63:0] x_img = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] y_real;
    logic [63:0] y_img;

    dit_ifft8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_real    (x_real),
        .x_img     (x_img),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_real    (y_real),
        .y_img     (y_img)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] yr;
        logic [63:0] yi;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          busy = 1'b0;
    bit          pend = 1'b0;
    bit          stall_req = 1'b0;
    int          stall = 0;
    logic [63:0] held_r;
    logic [63:0] held_i;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference IFFT: bit-reversed load, then log2(8) stages of scaled butterflies
    function automatic void ifft_model(input logic [63:0] xr, input logic [63:0] xi,
                                       output logic [63:0] yr, output logic [63:0] yi);
        int re[8];
        int im[8];
        int cw[4];
        int sw[4];
        cw = '{128, 91, 0, -91};
        sw = '{0, 91, 128, 91};
        for (int k = 0; k < 8; k++) begin
            int r;
            logic signed [7:0] vr;
            logic signed [7:0] vi;
            r  = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
            vr = xr[8*k +: 8];
            vi = xi[8*k +: 8];
            re[r] = vr;
            im[r] = vi;
        end
        for (int s = 0; s < 3; s++) begin
            int half;
            half = 1 << s;
            for (int j = 0; j < 8; j++) begin
                if (((j >> s) & 1) == 0) begin
                    int q, tw, tr, ti, ar, ai;
                    q  = j + half;
                    tw = (j % half) * (4 >> s);
                    tr = (re[q] * cw[tw] - im[q] * sw[tw]) >>> 7;
                    ti = (re[q] * sw[tw] + im[q] * cw[tw]) >>> 7;
                    ar = re[j];
                    ai = im[j];
                    re[j] = sat((ar + tr) >>> 1);
                    im[j] = sat((ai + ti) >>> 1);
                    re[q] = sat((ar - tr) >>> 1);
                    im[q] = sat((ai - ti) >>> 1);
                end
            end
        end
        for (int n = 0; n < 8; n++) begin
            yr[8*n +: 8] = 8'(re[n]);
            yi[8*n +: 8] = 8'(im[n]);
        end
    endfunction

    function automatic logic [63:0] rnd_word();
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 5))
                0:       w[8*i +: 8] = 8'h7f;
                1:       w[8*i +: 8] = 8'h80;
                2:       w[8*i +: 8] = 8'h81;
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    // Monitor: pops on first out_valid cycle, checks hold/backpressure, drives out_ready
    always @(negedge clk) begin
        if (!rst) begin
            busy      = 1'b0;
            pend      = 1'b0;
            out_ready = 1'b0;
        end else begin
            if (pend) begin
                chk("in_ready_after_hs", 64'(in_ready), 64'd1);
                chk("out_valid_drop", 64'(out_valid), 64'd0);
                pend = 1'b0;
            end
            if (out_valid) begin
                if (!busy) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: y_real %h with empty scoreboard", y_real);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("y_real", y_real, e.yr);
                        chk("y_img", y_img, e.yi);
                        chk("latency", 64'(cyc - e.acc), 64'd12);
                    end
                    held_r    = y_real;
                    held_i    = y_img;
                    busy      = 1'b1;
                    stall     = stall_req ? 20 : int'($urandom_range(0, 3));
                    stall_req = 1'b0;
                end else begin
                    chk("hold_y_real", y_real, held_r);
                    chk("hold_y_img", y_img, held_i);
                    chk("in_ready_low_in_done", 64'(in_ready), 64'd0);
                end
                if (stall == 0) begin
                    out_ready = 1'b1;
                    busy      = 1'b0;
                    pend      = 1'b1;
                end else begin
                    stall--;
                    out_ready = 1'b0;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
    end

    task automatic send(input logic [63:0] xr, input logic [63:0] xi,
                        input logic [63:0] er, input logic [63:0] ei, input bit pulse);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
            return;
        end
        x_real   = xr;
        x_img    = xi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_real   = {$urandom, $urandom};
        x_img    = {$urandom, $urandom};
        e.yr  = er;
        e.yi  = ei;
        e.acc = cyc;
        sb.push_back(e);
        if (pulse) begin
            repeat (3) @(negedge clk);
            in_valid = 1'b1;
            x_real   = {$urandom, $urandom};
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || busy || out_valid) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || busy || out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d frames still pending", sb.size());
        end
    endtask

    logic [63:0] dc_r;
    logic [63:0] one_r;

    initial begin
        logic [63:0] xr, xi, er, ei;
        dc_r  = pk(8, 0, 0, 0, 0, 0, 0, 0);
        one_r = pk(1, 1, 1, 1, 1, 1, 1, 1);

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y_real", y_real, 64'd0);
        chk("reset_y_img", y_img, 64'd0);
        rst = 1'b1;

        // DC bin, flat spectrum, single tone (with a stray in_valid during CALC)
        send(dc_r, 64'd0, one_r, 64'd0, 1'b0);
        send(pk(8, 8, 8, 8, 8, 8, 8, 8), 64'd0, pk(8, 0, 0, 0, 0, 0, 0, 0), 64'd0, 1'b0);
        send(pk(0, 64, 0, 0, 0, 0, 0, 0), 64'd0,
             pk(8, 5, 0, -6, -8, -6, 0, 6), pk(0, 5, 8, 5, 0, -6, -8, -6), 1'b1);
        drain();

        // Long backpressure on one frame
        stall_req = 1'b1;
        send(dc_r, 64'd0, one_r, 64'd0, 1'b0);
        drain();

        // Reset in the middle of CALC aborts the frame
        send(dc_r, 64'd0, one_r, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_y_real", y_real, 64'd0);
        chk("abort_y_img", y_img, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(dc_r, 64'd0, one_r, 64'd0, 1'b0);
        drain();

        // Random frames with saturating extremes
        for (int f = 0; f < 200; f++) begin
            xr = rnd_word();
            xi = rnd_word();
            ifft_model(xr, xi, er, ei);
            send(xr, xi, er, ei, ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dit_ifft8.md
# dit_ifft8

Iterative 8-point radix-2 decimation-in-time inverse FFT. It is the inverse counterpart of `DIT_FFT`. It accepts one frame of 8 complex frequency-domain samples in 8-bit two's complement over a valid/ready handshake. It computes the time-domain frame with one time-shared butterfly, applying 1/2 scaling per stage so that the total scaling is the 1/8 required by the IFFT. It then presents the result on a held valid/ready output, and sits downstream of `DIT_FFT` in the processing chain.

## Interface
- No parameters; the block is fixed at N=8 and 8-bit data.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  input frame present
- in_ready  out  1  block can accept a frame
- x_real  in  64  X_k real part at [8k+7:8k], k=0..7, signed
- x_img  in  64  X_k imaginary part, same packing
- out_valid  out  1  result frame held on y_*
- out_ready  in  1  consumer accepts the frame
- y_real  out  64  y_n real part at [8n+7:8n], signed, natural order
- y_img  out  64  y_n imaginary part, same packing

## Operation
- Working memory: 8 complex registers, 8 bits each, for real and for imaginary.
- FSM states:
  - IDLE: in_ready=1.
  - CALC: 12 cycles, one butterfly per cycle, stage counter s=0..2, butterfly counter b=0..3.
  - DONE: out_valid=1.
- IDLE -> CALC on in_valid at a clock edge. On that edge, load mem[bitrev3(k)] = X_k.
- CALC -> DONE after butterfly (s=2, b=3). On that edge, y_* is registered from the final memory.
- DONE -> IDLE on the edge where out_ready=1.
- Butterfly pairs (p, q) and twiddle index k, listed in b order:
  - s=0: (0,1) (2,3) (4,5) (6,7), k=0 for all.
  - s=1: (0,2) (1,3) (4,6) (5,7), k=0,2,0,2.
  - s=2: (0,4) (1,5) (2,6) (3,7), k=0,1,2,3.
- Twiddle W^-k, with (C,S) in Q1.7 integers:
  - k0 = (128, 0)
  - k1 = (91, 91)
  - k2 = (0, 128)
  - k3 = (-91, 91)
- Butterfly arithmetic, with A=mem[p], B=mem[q] (all signed):
  - t_re = (Br*C - Bi*S) >>> 7
  - t_im = (Br*S + Bi*C) >>> 7
  - Products are at least 17 bits; t is 10 bits.
  - mem[p] = sat8((A + t) >>> 1)
  - mem[q] = sat8((A - t) >>> 1)
  - Sums are 11 bits. `>>>` is an arithmetic shift (truncation toward -inf). sat8 clamps to [-128, 127].
- Only one butterfly executes per cycle, so there is no read-after-write hazard within a stage.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, y_real=y_img=0, memory=0, counters=0.
- Frame acceptance edge T:
  - in_ready drops after T.
  - Butterflies execute on edges T+1..T+12.
  - out_valid=1 from just after T+12.
  - Latency is 12 cycles from acceptance to out_valid.
- The output is held stable while out_valid=1 && out_ready=0, for unbounded backpressure.
- On the edge where out_valid && out_ready:
  - out_valid drops; y_* keeps its last value.
  - in_ready=1 from the next cycle.
  - Minimum frame spacing is 14 cycles.
- in_valid outside IDLE is ignored; x_* is sampled only at the acceptance edge.
- Reset asserted mid-CALC or in DONE aborts the frame immediately: outputs return to their reset values and no partial result is ever presented.
- in_valid held high continuously causes a new frame to be accepted each time the FSM reaches IDLE.

## Test plan
- DC bin: X0=(8,0), all other X_k=0 -> after 12 cycles, y_n=(1,0) for all n.
- Flat spectrum: all X_k=(8,0) -> y0=(8,0), y1..y7=(0,0).
- Single tone: X1=(64,0), others 0 -> exact outputs required:
  - y0=(8,0), y1=(5,5), y2=(0,8), y3=(-6,5)
  - y4=(-8,0), y5=(-6,-6), y6=(0,-8), y7=(6,-6)
- Handshake:
  - Hold out_ready=0 for 20 cycles after out_valid -> y_* stable and in_ready=0 throughout.
  - Pulse out_ready -> in_ready=1 on the next cycle.
  - in_valid pulsed during CALC -> no effect on the frame in progress.
- Reset abort: assert rst=0 at cycle 6 of CALC -> out_valid=0, in_ready=1 and y_*=0 immediately. After release, a fresh DC frame gives the DC result.
- Saturation and random: 200 random frames, including ±127/-128 extremes that drive sat8 -> bit-exact match against a model of the Operation arithmetic.
